mem_req_sched: RTL and testbench

- Sequential arbiter and scheduler between the instruction cache, the data cache and the single-ported main memory.
- Accepts one block request at a time from either cache and holds it stable toward main memory until main memory accepts it.
- For reads, waits for the matching response and routes the block back to the requesting cache.
- Icache has priority; a bounded starvation counter guarantees dcache forward progress.

---
 rtl/mem_req_sched_if.sv | 81 ++++++++
 rtl/mem_req_sched.sv | 203 ++++++++++++++++++++
 tb/tb_mem_req_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_sched_if.sv
// Shared types and the bundled request/response interface used between
// the caches, the memory request scheduler and main memory.

package mem_req_sched_pkg;
  localparam int BLOCK_ADDR_W = 10;
  localparam int BLOCK_DATA_W = 32;

  typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_W-1:0] block_data_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } cache_type_t;
endpackage

interface mem_req_sched_if;
  import mem_req_sched_pkg::*;

  // Icache request channel
  logic                 icache_req_valid;
  main_mem_block_addr_t icache_req_block_addr;
  logic                 icache_req_ready;

  // Dcache request channel
  logic                 dcache_req_valid;
  req_type_t            dcache_req_type;
  main_mem_block_addr_t dcache_req_block_addr;
  block_data_t          dcache_req_block_data;
  logic                 dcache_req_ready;

  // Main memory request channel
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  cache_type_t          mem_req_cache_type;
  req_type_t            mem_req_type;
  main_mem_block_addr_t mem_req_block_addr;
  block_data_t          mem_req_block_data;

  // Main memory response channel
  logic                 mem_resp_valid;
  cache_type_t          mem_resp_cache_type;
  block_data_t          mem_resp_block_data;

  // Read data back to the caches
  logic                 icache_resp_valid;
  block_data_t          icache_resp_block_data;
  logic                 dcache_resp_valid;
  block_data_t          dcache_resp_block_data;

  // Scheduler side
  modport master (
    input  icache_req_valid, icache_req_block_addr,
    output icache_req_ready,
    input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
    output dcache_req_ready,
    output mem_req_valid, mem_req_cache_type, mem_req_type, mem_req_block_addr, mem_req_block_data,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_cache_type, mem_resp_block_data,
    output icache_resp_valid, icache_resp_block_data,
    output dcache_resp_valid, dcache_resp_block_data
  );

  // Cache / memory side
  modport slave (
    output icache_req_valid, icache_req_block_addr,
    input  icache_req_ready,
    output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
    input  dcache_req_ready,
    input  mem_req_valid, mem_req_cache_type, mem_req_type, mem_req_block_addr, mem_req_block_data,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_cache_type, mem_resp_block_data,
    input  icache_resp_valid, icache_resp_block_data,
    input  dcache_resp_valid, dcache_resp_block_data
  );
endinterface

// File: rtl/mem_req_sched.sv
// Memory request scheduler: arbitrates one block request at a time between
// the icache and the dcache toward single-ported main memory, holds it until
// accepted, and routes read responses back to the requester. Icache wins
// ties unless the dcache has been passed over STARVE_LIMIT times in a row.

module mem_req_sched
  import mem_req_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_aL,
  mem_req_sched_if.master bus,
  output logic busy,
  output logic resp_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam main_mem_block_addr_t ADDR_ZERO = {BLOCK_ADDR_W{1'b0}};
  localparam block_data_t          DATA_ZERO = {BLOCK_DATA_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 icache_grant_s;
  logic                 dcache_grant_s;
  logic                 starve_hit_s;
  logic                 resp_match_s;
  logic                 issue_done_s;

  logic [CNT_W-1:0]     starve_cnt_r;
  cache_type_t          req_cache_r;
  req_type_t            req_type_r;

  logic                 mem_req_valid_r;
  cache_type_t          mem_req_cache_type_r;
  req_type_t            mem_req_type_r;
  main_mem_block_addr_t mem_req_block_addr_r;
  block_data_t          mem_req_block_data_r;

  logic                 icache_resp_valid_r;
  block_data_t          icache_resp_block_data_r;
  logic                 dcache_resp_valid_r;
  block_data_t          dcache_resp_block_data_r;
  logic                 resp_err_r;

  // Grant arbitration (IDLE only, suppressed during reset) and next-state selection
  always_comb begin
    state_nxt_s    = state_r;
    icache_grant_s = 1'b0;
    dcache_grant_s = 1'b0;
    starve_hit_s   = (starve_cnt_r == STARVE_MAX);
    resp_match_s   = bus.mem_resp_valid && (bus.mem_resp_cache_type == req_cache_r);
    issue_done_s   = (state_r == ISSUE) && bus.mem_req_ready;
    case (state_r)
      IDLE: begin
        if (!rst_aL) begin
          state_nxt_s = IDLE;
        end else if (bus.icache_req_valid && !(bus.dcache_req_valid && starve_hit_s)) begin
          icache_grant_s = 1'b1;
          state_nxt_s    = ISSUE;
        end else if (bus.dcache_req_valid) begin
          dcache_grant_s = 1'b1;
          state_nxt_s    = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          // Writes complete on acceptance; only reads wait for data
          if (req_type_r == WRITE) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT_RESP;
          end
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (resp_match_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the winning request; memory-facing fields read zero outside ISSUE
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      req_cache_r          <= ICACHE;
      req_type_r           <= READ;
      mem_req_valid_r      <= 1'b0;
      mem_req_cache_type_r <= ICACHE;
      mem_req_type_r       <= READ;
      mem_req_block_addr_r <= ADDR_ZERO;
      mem_req_block_data_r <= DATA_ZERO;
    end else if (icache_grant_s) begin
      req_cache_r          <= ICACHE;
      req_type_r           <= READ;
      mem_req_valid_r      <= 1'b1;
      mem_req_cache_type_r <= ICACHE;
      mem_req_type_r       <= READ;
      mem_req_block_addr_r <= bus.icache_req_block_addr;
      mem_req_block_data_r <= DATA_ZERO;
    end else if (dcache_grant_s) begin
      req_cache_r          <= DCACHE;
      req_type_r           <= bus.dcache_req_type;
      mem_req_valid_r      <= 1'b1;
      mem_req_cache_type_r <= DCACHE;
      mem_req_type_r       <= bus.dcache_req_type;
      mem_req_block_addr_r <= bus.dcache_req_block_addr;
      mem_req_block_data_r <= (bus.dcache_req_type == WRITE) ? bus.dcache_req_block_data
                                                               : DATA_ZERO;
    end else if (issue_done_s) begin
      mem_req_valid_r      <= 1'b0;
      mem_req_cache_type_r <= ICACHE;
      mem_req_type_r       <= READ;
      mem_req_block_addr_r <= ADDR_ZERO;
      mem_req_block_data_r <= DATA_ZERO;
    end
  end

  // Count consecutive icache wins over a waiting dcache, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      starve_cnt_r <= CNT_ZERO;
    end else if (icache_grant_s) begin
      if (!bus.dcache_req_valid) begin
        starve_cnt_r <= CNT_ZERO;
      end else if (!starve_hit_s) begin
        starve_cnt_r <= starve_cnt_r + CNT_ONE;
      end
    end else if (dcache_grant_s) begin
      starve_cnt_r <= CNT_ZERO;
    end
  end

  // Route matching read data as a one-cycle pulse; flag any stray or mistagged response
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      icache_resp_valid_r      <= 1'b0;
      icache_resp_block_data_r <= DATA_ZERO;
      dcache_resp_valid_r      <= 1'b0;
      dcache_resp_block_data_r <= DATA_ZERO;
      resp_err_r               <= 1'b0;
    end else begin
      icache_resp_valid_r <= 1'b0;
      dcache_resp_valid_r <= 1'b0;
      if (bus.mem_resp_valid) begin
        if ((state_r == WAIT_RESP) && resp_match_s) begin
          if (req_cache_r == ICACHE) begin
            icache_resp_valid_r      <= 1'b1;
            icache_resp_block_data_r <= bus.mem_resp_block_data;
          end else begin
            dcache_resp_valid_r      <= 1'b1;
            dcache_resp_block_data_r <= bus.mem_resp_block_data;
          end
        end else begin
          resp_err_r <= 1'b1;
        end
      end
    end
  end

  assign bus.icache_req_ready       = icache_grant_s;
  assign bus.dcache_req_ready       = dcache_grant_s;
  assign bus.mem_req_valid          = mem_req_valid_r;
  assign bus.mem_req_cache_type     = mem_req_cache_type_r;
  assign bus.mem_req_type           = mem_req_type_r;
  assign bus.mem_req_block_addr     = mem_req_block_addr_r;
  assign bus.mem_req_block_data     = mem_req_block_data_r;
  assign bus.icache_resp_valid      = icache_resp_valid_r;
  assign bus.icache_resp_block_data = icache_resp_block_data_r;
  assign bus.dcache_resp_valid      = dcache_resp_valid_r;
  assign bus.dcache_resp_block_data = dcache_resp_block_data_r;
  assign busy                       = (state_r != IDLE);
  assign resp_err                   = resp_err_r;

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched: inputs change 1ns after the rising edge,
// outputs are compared on the falling edge.

module tb_mem_req_sched;
  import mem_req_sched_pkg::*;

  logic clk;
  logic rst_aL;
  logic busy;
  logic resp_err;
  int   total_cnt;
  int   pass_cnt;

  mem_req_sched_if bus ();

  mem_req_sched #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_aL   (rst_aL),
    .bus      (bus.master),
    .busy     (busy),
    .resp_err (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.icache_req_valid      = 1'b0;
    bus.icache_req_block_addr = 10'h000;
    bus.dcache_req_valid      = 1'b0;
    bus.dcache_req_type       = READ;
    bus.dcache_req_block_addr = 10'h000;
    bus.dcache_req_block_data = 32'h0;
    bus.mem_req_ready         = 1'b0;
    bus.mem_resp_valid        = 1'b0;
    bus.mem_resp_cache_type   = ICACHE;
    bus.mem_resp_block_data   = 32'h0;
  endtask

  task automatic test_reset();
    rst_aL = 1'b0;
    clear_inputs();
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 10'h001;
    bus.dcache_req_valid      = 1'b1;
    bus.dcache_req_block_addr = 10'h002;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b00)
      $display("FAIL reset_readys: actual %b required 00", {bus.icache_req_ready, bus.dcache_req_ready});
    else pass_cnt++;
    total_cnt++;
    if (bus.mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid: actual %b required 0", bus.mem_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: actual %b required 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (resp_err !== 1'b0) $display("FAIL reset_resp_err: actual %b required 0", resp_err);
    else pass_cnt++;
    next_cycle();
    rst_aL = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b10)
      $display("FAIL reset_first_grant: actual %b required 10", {bus.icache_req_ready, bus.dcache_req_ready});
    else pass_cnt++;
    next_cycle();
    rst_aL = 1'b0;
    clear_inputs();
    next_cycle();
    rst_aL = 1'b1;
  endtask

  task automatic test_icache_read();
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 10'h012;
    @(negedge clk);
    total_cnt++;
    if (bus.icache_req_ready !== 1'b1) $display("FAIL iread_grant: actual %b required 1", bus.icache_req_ready);
    else pass_cnt++;
    next_cycle();
    bus.icache_req_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_req_valid, bus.mem_req_cache_type, bus.mem_req_type, bus.mem_req_block_addr, bus.mem_req_block_data}
        !== {1'b1, ICACHE, READ, 10'h012, 32'h0})
      $display("FAIL iread_req_t1: actual v=%b c=%0d t=%0d a=%0h d=%0h required v=1 c=0 t=0 a=12 d=0",
               bus.mem_req_valid, bus.mem_req_cache_type, bus.mem_req_type, bus.mem_req_block_addr, bus.mem_req_block_data);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_req_valid, bus.mem_req_block_addr} !== {1'b1, 10'h012})
      $display("FAIL iread_req_t2: actual v=%b a=%0h required v=1 a=12", bus.mem_req_valid, bus.mem_req_block_addr);
    else pass_cnt++;
    next_cycle();
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_req_valid, bus.mem_req_block_addr} !== {1'b1, 10'h012})
      $display("FAIL iread_req_t3: actual v=%b a=%0h required v=1 a=12", bus.mem_req_valid, bus.mem_req_block_addr);
    else pass_cnt++;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_req_valid, bus.mem_req_block_addr, busy} !== {1'b0, 10'h000, 1'b1})
      $display("FAIL iread_wait: actual v=%b a=%0h busy=%b required v=0 a=0 busy=1",
               bus.mem_req_valid, bus.mem_req_block_addr, busy);
    else pass_cnt++;
    next_cycle();
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_cache_type = ICACHE;
    bus.mem_resp_block_data = 32'h0000_00A5;
    @(negedge clk);
    total_cnt++;
    if (bus.icache_resp_valid !== 1'b0) $display("FAIL iread_no_early_pulse: actual %b required 0", bus.icache_resp_valid);
    else pass_cnt++;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_resp_valid, bus.icache_resp_block_data, bus.dcache_resp_valid, busy}
        !== {1'b1, 32'h0000_00A5, 1'b0, 1'b0})
      $display("FAIL iread_resp: actual iv=%b id=%0h dv=%b busy=%b required iv=1 id=a5 dv=0 busy=0",
               bus.icache_resp_valid, bus.icache_resp_block_data, bus.dcache_resp_valid, busy);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_resp_valid, bus.icache_resp_block_data} !== {1'b0, 32'h0000_00A5})
      $display("FAIL iread_pulse_end: actual iv=%b id=%0h required iv=0 id=a5",
               bus.icache_resp_valid, bus.icache_resp_block_data);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_dcache_write();
    bus.dcache_req_valid      = 1'b1;
    bus.dcache_req_type       = WRITE;
    bus.dcache_req_block_addr = 10'h007;
    bus.dcache_req_block_data = 32'h0000_DEAD;
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b01)
      $display("FAIL dwrite_grant: actual %b required 01", {bus.icache_req_ready, bus.dcache_req_ready});
    else pass_cnt++;
    next_cycle();
    bus.dcache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_req_valid, bus.mem_req_cache_type, bus.mem_req_type, bus.mem_req_block_addr, bus.mem_req_block_data}
        !== {1'b1, DCACHE, WRITE, 10'h007, 32'h0000_DEAD})
      $display("FAIL dwrite_req: actual v=%b c=%0d t=%0d a=%0h d=%0h required v=1 c=1 t=1 a=7 d=dead",
               bus.mem_req_valid, bus.mem_req_cache_type, bus.mem_req_type, bus.mem_req_block_addr, bus.mem_req_block_data);
    else pass_cnt++;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_req_valid, busy, bus.dcache_resp_valid, bus.icache_resp_valid} !== 4'b0000)
      $display("FAIL dwrite_done: actual v=%b busy=%b dv=%b iv=%b required all 0",
               bus.mem_req_valid, busy, bus.dcache_resp_valid, bus.icache_resp_valid);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if ({bus.dcache_resp_valid, busy} !== 2'b00)
      $display("FAIL dwrite_no_resp: actual dv=%b busy=%b required 0 0", bus.dcache_resp_valid, busy);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_grant;
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 10'h040;
    bus.dcache_req_valid      = 1'b1;
    bus.dcache_req_type       = WRITE;
    bus.dcache_req_block_addr = 10'h050;
    bus.dcache_req_block_data = 32'h1234_5678;
    bus.mem_req_ready         = 1'b1;
    for (int g = 0; g < 7; g++) begin
      exp_grant = (g == 4) ? 2'b01 : 2'b10;
      @(negedge clk);
      total_cnt++;
      if ({bus.icache_req_ready, bus.dcache_req_ready} !== exp_grant)
        $display("FAIL starve_grant_%0d: actual %b required %b", g + 1,
                 {bus.icache_req_ready, bus.dcache_req_ready}, exp_grant);
      else pass_cnt++;
      next_cycle();
      next_cycle();
      if (exp_grant == 2'b10) begin
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_cache_type = ICACHE;
        bus.mem_resp_block_data = 32'h100 + 32'(g);
        next_cycle();
        bus.mem_resp_valid = 1'b0;
      end
    end
    clear_inputs();
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_resp_valid, bus.icache_resp_block_data, resp_err} !== {1'b1, 32'h0000_0106, 1'b0})
      $display("FAIL starve_last_resp: actual iv=%b id=%0h err=%b required iv=1 id=106 err=0",
               bus.icache_resp_valid, bus.icache_resp_block_data, resp_err);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_mismatch();
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 10'h033;
    next_cycle();
    bus.icache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    next_cycle();
    bus.mem_req_ready       = 1'b0;
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_cache_type = DCACHE;
    bus.mem_resp_block_data = 32'h0000_0011;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_resp_valid, bus.dcache_resp_valid, resp_err, busy} !== 4'b0011)
      $display("FAIL mismatch_err: actual iv=%b dv=%b err=%b busy=%b required 0 0 1 1",
               bus.icache_resp_valid, bus.dcache_resp_valid, resp_err, busy);
    else pass_cnt++;
    next_cycle();
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_cache_type = ICACHE;
    bus.mem_resp_block_data = 32'h0000_0077;
    @(negedge clk);
    total_cnt++;
    if (resp_err !== 1'b1) $display("FAIL mismatch_sticky: actual %b required 1", resp_err);
    else pass_cnt++;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_resp_valid, bus.icache_resp_block_data, resp_err, busy} !== {1'b1, 32'h0000_0077, 1'b1, 1'b0})
      $display("FAIL mismatch_recover: actual iv=%b id=%0h err=%b busy=%b required iv=1 id=77 err=1 busy=0",
               bus.icache_resp_valid, bus.icache_resp_block_data, resp_err, busy);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_midtxn();
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 10'h044;
    next_cycle();
    bus.icache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    rst_aL            = 1'b0;
    next_cycle();
    rst_aL = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy, resp_err, bus.icache_resp_block_data} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL midrst_cleared: actual busy=%b err=%b id=%0h required 0 0 0",
               busy, resp_err, bus.icache_resp_block_data);
    else pass_cnt++;
    next_cycle();
    bus.mem_resp_valid        = 1'b1;
    bus.mem_resp_cache_type   = ICACHE;
    bus.mem_resp_block_data   = 32'h0000_0055;
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 10'h066;
    @(negedge clk);
    total_cnt++;
    if (bus.icache_req_ready !== 1'b1) $display("FAIL midrst_granting: actual %b required 1", bus.icache_req_ready);
    else pass_cnt++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total_cnt++;
    if ({bus.icache_resp_valid, resp_err, bus.mem_req_valid, bus.mem_req_block_addr} !== {1'b0, 1'b1, 1'b1, 10'h066})
      $display("FAIL midrst_late_resp: actual iv=%b err=%b v=%b a=%0h required iv=0 err=1 v=1 a=66",
               bus.icache_resp_valid, resp_err, bus.mem_req_valid, bus.mem_req_block_addr);
    else pass_cnt++;
    next_cycle();
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_starvation();
    test_mismatch();
    test_reset_midtxn();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
